// File: rtl/arb_pkg.sv
// Shared types and defaults for the cache port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: purely combinational grant, fairness from last_grant.
module rr_arb2
  import arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_e last_grant_i,
  output logic   i_gnt_o,
  output logic   d_gnt_o
);

  // Fetch yields only when both ask and fetch was the one served last.
  always_comb begin
    i_gnt_o = i_req_i && (!d_req_i || (last_grant_i != OWN_INSTR));
    d_gnt_o = d_req_i && !i_gnt_o;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache port between instruction fetch and data access.
// IDLE accepts, BUSY holds strobes until completion or timeout, RESP pulses done.
module cache_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_valid,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_be,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [7:0]        mem_byte_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_data_valid,
  input  logic              mem_write_complete,
  output logic              err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        be_q, be_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic i_gnt, d_gnt;
  logic finished;
  logic fetch_killed;

  rr_arb2 u_rr_arb2 (
    .i_req_i      (i_valid),
    .d_req_i      (d_valid),
    .last_grant_i (last_q),
    .i_gnt_o      (i_gnt),
    .d_gnt_o      (d_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      last_q   <= OWN_DATA;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  // Only the completion matching the latched direction ends BUSY.
  assign finished = write_q ? mem_write_complete : mem_data_valid;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    err_d    = err_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_gnt || d_gnt) begin
          state_d = ST_BUSY;
          owner_d = i_gnt ? OWN_INSTR : OWN_DATA;
          addr_d  = i_gnt ? i_addr : d_addr;
          wdata_d = i_gnt ? '0 : d_wdata;
          be_d    = i_gnt ? '0 : d_be;
          write_d = d_gnt && d_write;
          cnt_d   = '0;
          kill_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_BUSY: begin
        if ((owner_q == OWN_INSTR) && i_flush) kill_d = 1'b1;
        if (finished) begin
          state_d = ST_RESP;
          if (!write_q && (owner_q == OWN_INSTR)) irdata_d = mem_read_data;
          if (!write_q && (owner_q == OWN_DATA))  drdata_d = mem_read_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        owner_d = OWN_NONE;
        kill_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flush during the RESP cycle itself still suppresses the fetch response.
  assign fetch_killed = kill_q || i_flush;

  assign i_done           = (state_q == ST_RESP) && (owner_q == OWN_INSTR) && !fetch_killed;
  assign d_done           = (state_q == ST_RESP) && (owner_q == OWN_DATA);
  assign err              = (state_q == ST_RESP) && err_q &&
                            !((owner_q == OWN_INSTR) && fetch_killed);
  assign mem_read_enable  = (state_q == ST_BUSY) && !write_q;
  assign mem_write_enable = (state_q == ST_BUSY) && write_q;
  assign mem_address      = addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_byte_enable  = be_q;
  assign i_rdata          = irdata_q;
  assign d_rdata          = drdata_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed scenarios with literal expectations, then random traffic against a transaction model.
module tb_cache_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_flush, i_done;
  logic [63:0] i_addr, i_rdata;
  logic        d_valid, d_write, d_done;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_be;
  logic        mem_read_enable, mem_write_enable;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic [7:0]  mem_byte_enable;
  logic        mem_data_valid, mem_write_complete, err;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who is being served, for how long, and with what outcome.
  bit          m_busy, m_resp, m_write, m_kill, m_err;
  int          m_bcnt, m_plan, m_own, m_last;
  logic [63:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [7:0]  m_be;

  // Random requester state.
  bit          ipend, dpend, rd_write;
  logic [63:0] ri_addr, rd_addr, rd_wdata;
  logic [7:0]  rd_be;

  cache_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_read_data(mem_read_data), .mem_data_valid(mem_data_valid),
    .mem_write_complete(mem_write_complete), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_write = 0; m_kill = 0; m_err = 0;
    m_bcnt = 0; m_own = -1; m_last = 1;
    m_addr = '0; m_wdata = '0; m_be = '0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic model_step();
    bit fin;
    if (reset) begin
      model_reset();
    end else if (m_resp) begin
      m_resp = 0;
      m_last = m_own;
      if (m_own == 0) ipend = 0;
      else dpend = 0;
    end else if (m_busy) begin
      if (m_own == 0 && i_flush) m_kill = 1;
      fin = m_write ? mem_write_complete : mem_data_valid;
      if (fin) begin
        if (!m_write && m_own == 0) m_irdata = mem_read_data;
        if (!m_write && m_own == 1) m_drdata = mem_read_data;
        m_busy = 0; m_resp = 1;
      end else if (m_bcnt + 1 == TO) begin
        m_err = 1; m_busy = 0; m_resp = 1;
      end else begin
        m_bcnt++;
      end
    end else if (i_valid || d_valid) begin
      if (i_valid && d_valid) m_own = (m_last == 0) ? 1 : 0;
      else m_own = i_valid ? 0 : 1;
      if (m_own == 0) begin
        m_addr = i_addr; m_wdata = '0; m_be = '0; m_write = 0;
      end else begin
        m_addr = d_addr; m_wdata = d_wdata; m_be = d_be; m_write = d_write;
      end
      m_busy = 1; m_bcnt = 0; m_kill = 0; m_err = 0;
      m_plan = $urandom_range(0, TO + 1);
    end
  endtask

  task automatic compare_model();
    bit e_id, e_dd, e_er;
    e_id = m_resp && m_own == 0 && !m_kill && !i_flush;
    e_dd = m_resp && m_own == 1;
    e_er = m_resp && m_err && !(m_own == 0 && (m_kill || i_flush));
    chk("model i_done", i_done, e_id);
    chk("model d_done", d_done, e_dd);
    chk("model err", err, e_er);
    chk("model mem_read_enable", mem_read_enable, m_busy && !m_write);
    chk("model mem_write_enable", mem_write_enable, m_busy && m_write);
    chk("model mem_address", mem_address, m_addr);
    chk("model mem_write_data", mem_write_data, m_wdata);
    chk("model mem_byte_enable", mem_byte_enable, m_be);
    chk("model i_rdata", i_rdata, m_irdata);
    chk("model d_rdata", d_rdata, m_drdata);
  endtask

  task automatic drive_done();
    #1;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    drive_done();
    advance();
  endtask

  initial begin
    reset = 1; i_valid = 0; i_addr = '0; i_flush = 0;
    d_valid = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_read_data = '0; mem_data_valid = 0; mem_write_complete = 0;
    ipend = 0; dpend = 0; rd_write = 0; ri_addr = '0; rd_addr = '0; rd_wdata = '0; rd_be = '0;
    model_reset();
    m_plan = 0;
    @(negedge clk); #1;
    advance();
    advance();
    reset = 0;

    drive_done();
    chk("rst i_done", i_done, 0);
    chk("rst d_done", d_done, 0);
    chk("rst err", err, 0);
    chk("rst mem_read_enable", mem_read_enable, 0);
    chk("rst mem_write_enable", mem_write_enable, 0);
    chk("rst mem_address", mem_address, 0);
    chk("rst mem_write_data", mem_write_data, 0);
    chk("rst mem_byte_enable", mem_byte_enable, 0);
    chk("rst i_rdata", i_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    advance();

    // Single fetch completing on its first BUSY cycle.
    i_valid = 1; i_addr = 64'h1000;
    drive_done(); chk("fetch idle ren", mem_read_enable, 0); advance();
    mem_data_valid = 1; mem_read_data = 64'h13;
    drive_done(); chk("fetch busy ren", mem_read_enable, 1);
    chk("fetch busy addr", mem_address, 64'h1000); chk("fetch busy i_done", i_done, 0); advance();
    mem_data_valid = 0;
    drive_done(); chk("fetch resp i_done", i_done, 1); chk("fetch resp i_rdata", i_rdata, 64'h13);
    chk("fetch resp ren", mem_read_enable, 0); advance();
    i_valid = 0;
    drive_done(); chk("fetch after i_done", i_done, 0); advance();

    // Contention from reset: INSTR, DATA, INSTR.
    reset = 1; tick(); reset = 0;
    i_valid = 1; i_addr = 64'h1004; d_valid = 1; d_write = 0; d_addr = 64'h3000;
    for (int c = 1; c <= 9; c++) begin
      mem_data_valid = (c % 3 == 2);
      mem_read_data = (c == 2) ? 64'h11 : (c == 5) ? 64'hD0D0 : 64'h22;
      drive_done();
      chk("rr i_done", i_done, (c == 3 || c == 9));
      chk("rr d_done", d_done, (c == 6));
      if (c == 2) chk("rr addr instr", mem_address, 64'h1004);
      if (c == 5) chk("rr addr data", mem_address, 64'h3000);
      advance();
    end
    i_valid = 0; d_valid = 0; mem_data_valid = 0;
    drive_done(); chk("rr i_rdata", i_rdata, 64'h22); chk("rr d_rdata", d_rdata, 64'hD0D0); advance();

    // Store with completion on its fourth BUSY cycle.
    d_valid = 1; d_write = 1; d_addr = 64'h2008; d_wdata = 64'hDEADBEEF; d_be = 8'h0F;
    for (int c = 1; c <= 6; c++) begin
      mem_write_complete = (c == 5);
      drive_done();
      if (c >= 2 && c <= 5) begin
        chk("store wen", mem_write_enable, 1);
        chk("store addr", mem_address, 64'h2008);
        chk("store wdata", mem_write_data, 64'hDEADBEEF);
        chk("store be", mem_byte_enable, 8'h0F);
      end
      chk("store d_done", d_done, (c == 6));
      if (c == 6) chk("store d_rdata kept", d_rdata, 64'hD0D0);
      advance();
    end
    d_valid = 0; d_write = 0; mem_write_complete = 0;

    // Load that never completes; stray and wrong-type completions ignored.
    d_valid = 1; d_addr = 64'h4000;
    for (int c = 1; c <= 10; c++) begin
      mem_data_valid = (c == 1);
      mem_write_complete = (c == 3);
      drive_done();
      chk("timeout d_done", d_done, (c == 10));
      chk("timeout err", err, (c == 10));
      if (c == 9) chk("timeout ren last busy", mem_read_enable, 1);
      advance();
    end
    d_valid = 0; mem_data_valid = 0; mem_write_complete = 0;
    drive_done(); chk("timeout d_rdata kept", d_rdata, 64'hD0D0); advance();

    // Flushed fetch: no i_done, pending data request granted next.
    i_addr = 64'h5000; d_valid = 1; d_addr = 64'h6000;
    for (int c = 1; c <= 8; c++) begin
      i_valid = (c <= 5);
      i_flush = (c == 2);
      mem_data_valid = (c == 4 || c == 7);
      mem_read_data = (c == 4) ? 64'h77 : 64'h99;
      drive_done();
      chk("flush i_done", i_done, 0);
      if (c == 5) chk("flush err", err, 0);
      if (c == 7) chk("flush data addr", mem_address, 64'h6000);
      if (c == 8) begin
        chk("flush d_done", d_done, 1);
        chk("flush d_rdata", d_rdata, 64'h99);
      end
      advance();
    end
    d_valid = 0; i_flush = 0; mem_data_valid = 0;

    // Reset on the second BUSY cycle, then a normal request.
    d_valid = 1; d_addr = 64'h7000;
    for (int c = 1; c <= 6; c++) begin
      reset = (c == 3);
      mem_data_valid = (c == 5);
      mem_read_data = 64'hAB;
      drive_done();
      chk("rstbusy d_done", d_done, (c == 6));
      if (c == 4) begin
        chk("rstbusy ren", mem_read_enable, 0);
        chk("rstbusy addr", mem_address, 0);
      end
      if (c == 5) chk("rstbusy re-accept addr", mem_address, 64'h7000);
      if (c == 6) chk("rstbusy d_rdata", d_rdata, 64'hAB);
      advance();
    end
    d_valid = 0; reset = 0; mem_data_valid = 0;
    ipend = 0; dpend = 0;

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if (!ipend && $urandom_range(0, 3) == 0) begin
        ipend = 1; ri_addr = {$urandom, $urandom};
      end
      if (!dpend && $urandom_range(0, 3) == 0) begin
        dpend = 1; rd_write = 1'($urandom_range(0, 1));
        rd_addr = {$urandom, $urandom}; rd_wdata = {$urandom, $urandom}; rd_be = 8'($urandom);
      end
      i_valid = ipend; i_addr = ri_addr;
      d_valid = dpend; d_write = rd_write; d_addr = rd_addr; d_wdata = rd_wdata; d_be = rd_be;
      i_flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 299) == 0);
      mem_read_data = {$urandom, $urandom};
      if (m_busy && m_bcnt == m_plan) begin
        mem_data_valid = !m_write; mem_write_complete = m_write;
      end else if (m_busy) begin
        mem_data_valid = m_write && ($urandom_range(0, 2) == 0);
        mem_write_complete = !m_write && ($urandom_range(0, 2) == 0);
      end else begin
        mem_data_valid = ($urandom_range(0, 3) == 0);
        mem_write_complete = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width of all address ports.
REQ-002 Parameter DATA_W, default 64, data width of all data ports.
REQ-003 Parameter TIMEOUT, default 255, maximum BUSY cycles before a transaction is aborted; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_valid  in  1  instruction-fetch read request; held until i_done.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 i_flush  in  1  fetch redirect; kills the response of an in-flight fetch.
REQ-009 i_done  out  1  one-cycle pulse: fetch complete, i_rdata valid.
REQ-010 i_rdata  out  DATA_W  fetched instruction word.
REQ-011 d_valid  in  1  data request; held until d_done.
REQ-012 d_write  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_be  in  8  store byte enables.
REQ-016 d_done  out  1  one-cycle pulse: data request complete.
REQ-017 d_rdata  out  DATA_W  load data.
REQ-018 mem_read_enable  out  1  cache read strobe, held through BUSY.
REQ-019 mem_write_enable  out  1  cache write strobe, held through BUSY.
REQ-020 mem_address / mem_write_data / mem_byte_enable  out  ADDR_W / DATA_W / 8  latched request fields to the cache.
REQ-021 mem_read_data  in  DATA_W; mem_data_valid  in  1; mem_write_complete  in  1  cache response.
REQ-022 err  out  1  one-cycle pulse, coincident with i_done/d_done, when the transaction timed out.

Function
REQ-023 FSM states IDLE, BUSY, RESP; owner register values NONE, INSTR, DATA.
REQ-024 IDLE: if any of i_valid/d_valid is high, latch winner's addr/wdata/be/write into registers, set owner, go BUSY next cycle; otherwise stay IDLE.
REQ-025 Arbitration is round-robin: with both valid, the requester not served last wins; last_grant resets to DATA, so INSTR wins first contention.
REQ-026 A single valid requester always wins, regardless of last_grant.
REQ-027 BUSY: mem_read_enable = !write_latched, mem_write_enable = write_latched; mem_* fields stable for the whole of BUSY; all strobes 0 outside BUSY.
REQ-028 BUSY exits to RESP on mem_data_valid (read) or mem_write_complete (write); read data captured into the owner's rdata register on that cycle.
REQ-029 BUSY cycle counter (16 bits) clears on entry; when it reaches TIMEOUT with no completion, go RESP with err flag set; rdata register unchanged.
REQ-030 RESP lasts exactly one cycle: pulse owner's done (and err if flagged), update last_grant to owner, go IDLE.
REQ-031 Minimum occupancy 3 cycles (IDLE accept, BUSY with same-cycle completion, RESP); back-to-back requests re-arbitrate in the IDLE following RESP.
REQ-032 i_flush high in any cycle while owner = INSTR in BUSY or RESP sets a kill flag; the memory transaction still completes, i_done and err are suppressed, FSM returns to IDLE normally.
REQ-033 i_flush in IDLE or with owner = DATA has no effect.
REQ-034 Completion signals arriving outside BUSY are ignored; the wrong-type completion in BUSY (write_complete on a read) is ignored.
REQ-035 i_rdata/d_rdata hold their last captured value until the next capture for that requester.

Reset
REQ-036 On reset: state IDLE, owner NONE, last_grant DATA, counter 0, kill and err flags 0, all done/err/strobe outputs 0, mem_* fields and rdata registers 0.
REQ-037 Reset mid-BUSY abandons the transaction with no done pulse; strobes drop in the cycle after reset is sampled.

Structure
REQ-038 Shared package arb_pkg holds the state enum, owner enum and the default TIMEOUT constant.
REQ-039 One sub-module rr_arb2 (two-request round-robin picker, combinational grant plus last_grant input) is instantiated; everything else is in cache_port_arbiter.

Verification
REQ-040 i_valid with i_addr=0x1000, mem_data_valid on 1st BUSY cycle, mem_read_data=0x00000013 -> mem_read_enable high 1 cycle, i_done at cycle 3, i_rdata=0x13.
REQ-041 i_valid and d_valid together from reset -> INSTR served first, then DATA, then INSTR on continued contention; no done overlap.
REQ-042 d_write=1, d_addr=0x2008, d_wdata=0xDEADBEEF, d_be=0x0F, write_complete after 4 cycles -> mem fields stable 4 cycles, d_done once, d_rdata unchanged.
REQ-043 Fetch in BUSY, i_flush pulsed, data_valid 2 cycles later -> no i_done, FSM IDLE, a pending d_valid is then granted.
REQ-044 TIMEOUT=8, no completion -> done and err pulse together after 8 BUSY cycles.
REQ-045 reset asserted on 2nd BUSY cycle -> all outputs 0 next cycle, no done pulse, new request accepted normally afterwards.
